// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared RegDesloc op codes, shift funct codes and sequencer states
package shift_pkg;

  // ROR/ROL exist in RegDesloc but this sequencer never issues them
  typedef enum logic [2:0] {
    OP_NOP     = 3'b000,
    OP_LOAD    = 3'b001,
    OP_LEFT    = 3'b010,
    OP_RIGHT_L = 3'b011,
    OP_RIGHT_A = 3'b100,
    OP_ROR     = 3'b101,
    OP_ROL     = 3'b110
  } shift_op_e;

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV = 6'b000111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } seq_state_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - control-side and shifter-side signals of the shift sequencer
interface shift_sequencer_if;
  logic        start;
  logic [5:0]  funct;
  logic [4:0]  shamt_field;
  logic [31:0] rs_value;
  logic [2:0]  shift_ctrl;
  logic [4:0]  shift_n;
  logic        busy;
  logic        done;
  logic        reg_write;
  logic        illegal;

  modport master (
    output start, funct, shamt_field, rs_value,
    input  shift_ctrl, shift_n, busy, done, reg_write, illegal
  );

  modport slave (
    input  start, funct, shamt_field, rs_value,
    output shift_ctrl, shift_n, busy, done, reg_write, illegal
  );
endinterface

// File: rtl/shift_decode.sv
// rtl/shift_decode.sv - maps an R-type shift funct to RegDesloc op and shift amount
module shift_decode
  import shift_pkg::*;
(
  input  logic [5:0] funct,
  input  logic [4:0] shamt_field,
  input  logic [4:0] rs_amount,
  output logic       valid,
  output shift_op_e  op,
  output logic [4:0] amount
);

  always_comb begin
    valid  = 1'b1;
    op     = OP_NOP;
    amount = shamt_field;
    case (funct)
      FUNCT_SLL:  op = OP_LEFT;
      FUNCT_SRL:  op = OP_RIGHT_L;
      FUNCT_SRA:  op = OP_RIGHT_A;
      FUNCT_SLLV: begin op = OP_LEFT;    amount = rs_amount; end
      FUNCT_SRLV: begin op = OP_RIGHT_L; amount = rs_amount; end
      FUNCT_SRAV: begin op = OP_RIGHT_A; amount = rs_amount; end
      default: begin
        valid  = 1'b0;
        amount = 5'd0;
      end
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - sequences RegDesloc through load and shift phases for MIPS shifts
module shift_sequencer
  import shift_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  shift_sequencer_if.slave bus
);

  seq_state_e state, state_nx;
  shift_op_e  op_q;
  logic [4:0] amt_q;
  logic       illegal_q;

  logic       dec_valid;
  shift_op_e  dec_op;
  logic [4:0] dec_amt;
  logic       accept;
  logic       reject;

  shift_op_e  shift_ctrl_c;
  logic [4:0] shift_n_c;
  logic       busy_c;
  logic       done_c;

  // MIPS variable shifts use only rs[4:0]; the upper bits are deliberately dropped
  logic unused_rs_hi;
  assign unused_rs_hi = ^bus.rs_value[31:5];

  shift_decode u_decode (
    .funct       (bus.funct),
    .shamt_field (bus.shamt_field),
    .rs_amount   (bus.rs_value[4:0]),
    .valid       (dec_valid),
    .op          (dec_op),
    .amount      (dec_amt)
  );

  assign accept = (state == ST_IDLE) && bus.start && dec_valid;
  assign reject = (state == ST_IDLE) && bus.start && !dec_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      op_q      <= OP_NOP;
      amt_q     <= 5'd0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_nx;
      illegal_q <= reject;
      if (accept) begin
        op_q  <= dec_op;
        amt_q <= dec_amt;
      end
    end
  end

  always_comb begin
    state_nx     = state;
    shift_ctrl_c = OP_NOP;
    shift_n_c    = 5'd0;
    busy_c       = 1'b1;
    done_c       = 1'b0;
    case (state)
      ST_IDLE: begin
        busy_c = 1'b0;
        if (accept) state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        shift_ctrl_c = OP_LOAD;
        state_nx     = (amt_q != 5'd0) ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        shift_ctrl_c = op_q;
        shift_n_c    = amt_q;
        state_nx     = ST_DONE;
      end
      ST_DONE: begin
        done_c   = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign bus.shift_ctrl = shift_ctrl_c;
  assign bus.shift_n    = shift_n_c;
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.reg_write  = done_c;
  assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - scoreboard bench for shift_sequencer
module tb_shift_sequencer;

  logic clk;
  logic reset;
  shift_sequencer_if bus ();

  shift_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit         ill;
    logic [2:0] op;
    logic [4:0] amt;
    int         done_cyc;
    int         load_cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   free_at = 0;

  logic [5:0] valid_functs [6] = '{6'b000000, 6'b000010, 6'b000011,
                                   6'b000100, 6'b000110, 6'b000111};

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: funct[2] selects variable amount, funct[1:0] selects direction
  task automatic model_issue(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] rs);
    exp_t e;
    logic [1:0] kind;
    kind = f[1:0];
    if (f[5:3] != 3'b000 || kind == 2'b01) begin
      e.ill = 1'b1; e.op = 3'd0; e.amt = 5'd0;
      e.done_cyc = cyc + 1; e.load_cyc = -1;
      free_at = cyc + 1;
    end else begin
      e.ill = 1'b0;
      e.amt = f[2] ? rs[4:0] : sh;
      e.op  = (kind == 2'b00) ? 3'd2 : (kind == 2'b10) ? 3'd3 : 3'd4;
      e.load_cyc = cyc + 1;
      e.done_cyc = (e.amt == 0) ? cyc + 2 : cyc + 3;
      free_at    = (e.amt == 0) ? cyc + 3 : cyc + 4;
    end
    sbq.push_back(e);
  endtask

  task automatic step(input bit st, input logic [5:0] f, input logic [4:0] sh, input logic [31:0] rs);
    bus.start = st; bus.funct = f; bus.shamt_field = sh; bus.rs_value = rs;
    if (st && cyc >= free_at) model_issue(f, sh, rs);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit st);
    exp_t keep[$];
    bus.start = st;
    bus.funct = 6'($urandom); bus.shamt_field = 5'($urandom); bus.rs_value = $urandom;
    reset = 1'b1;
    foreach (sbq[i]) if (sbq[i].done_cyc <= cyc) keep.push_back(sbq[i]);
    sbq = keep;
    free_at = cyc + 1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_shift_ctrl"}, 32'(bus.shift_ctrl), 0);
    check({tag, "_shift_n"},    32'(bus.shift_n), 0);
    check({tag, "_busy"},       32'(bus.busy), 0);
    check({tag, "_done"},       32'(bus.done), 0);
    check({tag, "_reg_write"},  32'(bus.reg_write), 0);
    check({tag, "_illegal"},    32'(bus.illegal), 0);
  endtask

  int         seen_load = -1;
  logic [2:0] seen_op = 3'd0;
  logic [4:0] seen_n = 5'd0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.shift_ctrl == 3'b001) seen_load = cyc;
    else if (bus.shift_ctrl != 3'b000) begin
      seen_op = bus.shift_ctrl;
      seen_n  = bus.shift_n;
    end
    if (bus.shift_ctrl <= 3'b001 && bus.shift_n != 5'd0)
      check("shift_n_outside_shift", 32'(bus.shift_n), 0);
    if (bus.done || bus.illegal) begin
      if (sbq.size() == 0) begin
        check("unexpected_output", {30'd0, bus.done, bus.illegal}, 0);
      end else begin
        e = sbq.pop_front();
        check("kind_illegal", 32'(bus.illegal), 32'(e.ill));
        check("output_cycle", cyc, e.done_cyc);
        check("out_shift_ctrl", 32'(bus.shift_ctrl), 0);
        if (e.ill) begin
          check("illegal_busy", 32'(bus.busy), 0);
        end else begin
          check("reg_write", 32'(bus.reg_write), 1);
          check("done_busy", 32'(bus.busy), 1);
          check("load_cycle", seen_load, e.load_cyc);
          check("shift_op", 32'(seen_op), (e.amt == 0) ? 0 : 32'(e.op));
          check("shift_amount", 32'(seen_n), 32'(e.amt));
        end
      end
      seen_load = -1; seen_op = 3'd0; seen_n = 5'd0;
    end
    if (reset) begin
      seen_load = -1; seen_op = 3'd0; seen_n = 5'd0;
    end
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.funct = 6'd0; bus.shamt_field = 5'd0; bus.rs_value = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    free_at = cyc;

    // sll by 4
    step(1'b1, 6'b000000, 5'd4, $urandom);
    repeat (4) step(1'b0, 6'b000000, 5'd4, 32'd0);

    // srav: only rs[4:0] counts and the amount is latched at accept
    step(1'b1, 6'b000111, 5'($urandom), 32'hFFFF_FFE3);
    step(1'b0, 6'b000111, 5'd0, 32'd0);
    repeat (3) step(1'b0, 6'b000000, 5'd0, 32'd0);

    // srl with zero amount skips SHIFT
    step(1'b1, 6'b000010, 5'd0, $urandom);
    repeat (3) step(1'b0, 6'b000000, 5'd0, 32'd0);

    // add funct is rejected
    step(1'b1, 6'b100000, 5'd3, 32'd7);
    repeat (2) step(1'b0, 6'b000000, 5'd0, 32'd0);

    // sllv with extra starts in LOAD and DONE, then one in the next IDLE
    step(1'b1, 6'b000100, 5'd0, 32'd9);
    step(1'b1, 6'b000000, 5'd2, 32'd0);
    step(1'b0, 6'b000000, 5'd0, 32'd0);
    step(1'b1, 6'b000011, 5'd1, 32'd0);
    step(1'b1, 6'b000010, 5'd7, 32'd0);
    repeat (5) step(1'b0, 6'b000000, 5'd0, 32'd0);

    // reset in SHIFT aborts without done, then sra by 31
    step(1'b1, 6'b000011, 5'd5, 32'd0);
    step(1'b0, 6'b000000, 5'd0, 32'd0);
    do_reset(1'b0);
    check_reset_outputs("abort");
    step(1'b1, 6'b000011, 5'd31, 32'd0);
    repeat (5) step(1'b0, 6'b000000, 5'd0, 32'd0);

    for (int i = 0; i < 400; i++) begin
      int r;
      logic [5:0] f;
      r = $urandom_range(0, 99);
      f = ($urandom_range(0, 99) < 85) ? valid_functs[$urandom_range(0, 5)] : 6'($urandom);
      if (r < 2) do_reset(1'($urandom));
      else step(r < 50, f, 5'($urandom), $urandom);
    end

    repeat (6) step(1'b0, 6'b000000, 5'd0, 32'd0);
    check("scoreboard_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
